// File: rtl/serial_peer_pkg.sv
// Shared constants and state types for the serial peer UART.
package serial_peer_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned FILTER_LEN = 4;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;
  typedef enum logic {TxIdle, TxShift} tx_state_t;

endpackage

// File: rtl/serial_peer_rx.sv
// Receive path: rx synchroniser, 4-sample majority-free noise filter and 8N1 framing FSM.
module serial_peer_rx
  import serial_peer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       rx_i,
  input  logic       rx_ack_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  filt_rx_q, filt_rx_d;
  rx_state_t             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b11;
      filt_q    <= '1;
      filt_rx_q <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      filt_q    <= filt_d;
      filt_rx_q <= filt_rx_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Filtered level only flips after FILTER_LEN agreeing samples; otherwise it holds.
  always_comb begin
    filt_d    = filt_q;
    filt_rx_d = filt_rx_q;
    if (tick_i) begin
      filt_d = {filt_q[FILTER_LEN-2:0], sync_q[1]};
      if (filt_d == '0) begin
        filt_rx_d = 1'b0;
      end else if (filt_d == '1) begin
        filt_rx_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (rx_ack_i) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (tick_i) begin
      if (state_q != RxIdle && cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        unique case (state_q)
          RxIdle: begin
            if (!filt_rx_q) begin
              state_d = RxStart;
              cnt_d   = 4'd7;
            end
          end
          RxStart: begin
            if (!filt_rx_q) begin
              state_d = RxData;
              cnt_d   = 4'd15;
              bit_d   = 3'd0;
            end else begin
              state_d = RxIdle;
            end
          end
          RxData: begin
            shift_d = {filt_rx_q, shift_q[7:1]};
            cnt_d   = 4'd15;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = RxStop;
            end
          end
          RxStop: begin
            state_d = RxIdle;
            if (filt_rx_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              ferr_d  = 1'b0;
              // A coincident ack consumed the old byte, so nothing is lost.
              if (valid_q && !rx_ack_i) begin
                ovr_d = 1'b1;
              end
            end else begin
              ferr_d = 1'b1;
            end
          end
          default: state_d = RxIdle;
        endcase
      end
    end
  end

  assign rx_data_o      = data_q;
  assign rx_valid_o     = valid_q;
  assign rx_frame_err_o = ferr_q;
  assign rx_overrun_o   = ovr_q;

endmodule

// File: rtl/serial_peer_uart.sv
// 8N1 UART peer of the CPU-side ACIA: free-running 16x prescaler, tx holding register + shifter.
module serial_peer_uart
  import serial_peer_pkg::*;
#(
  parameter int unsigned ClksPerBit = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       tx_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ack_i,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o
);

  localparam int unsigned TickDiv = ClksPerBit / OVERSAMPLE;
  localparam int unsigned PrescW  = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;

  tx_state_t  tx_state_q, tx_state_d;
  logic [9:0] tx_shift_q, tx_shift_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;

  assign tick    = (presc_q == PrescW'(TickDiv - 1));
  assign presc_d = tick ? '0 : presc_q + PrescW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q     <= '0;
      tx_state_q  <= TxIdle;
      tx_shift_q  <= '1;
      tx_tick_q   <= '0;
      tx_bit_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_tick_q   <= tx_tick_d;
      tx_bit_q    <= tx_bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_shift_d  = tx_shift_q;
    tx_tick_d   = tx_tick_q;
    tx_bit_d    = tx_bit_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
    if (tick) begin
      unique case (tx_state_q)
        TxIdle: begin
          if (hold_full_q) begin
            tx_state_d  = TxShift;
            tx_shift_d  = {1'b1, hold_q, 1'b0};
            tx_tick_d   = 4'd0;
            tx_bit_d    = 4'd0;
            hold_full_d = 1'b0;
          end
        end
        TxShift: begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'(OVERSAMPLE - 1)) begin
            if (tx_bit_q == 4'd9) begin
              // End of stop bit: chain straight into a waiting byte with no idle gap.
              if (hold_full_q) begin
                tx_shift_d  = {1'b1, hold_q, 1'b0};
                tx_bit_d    = 4'd0;
                hold_full_d = 1'b0;
              end else begin
                tx_state_d = TxIdle;
              end
            end else begin
              tx_shift_d = {1'b1, tx_shift_q[9:1]};
              tx_bit_d   = tx_bit_q + 4'd1;
            end
          end
        end
        default: tx_state_d = TxIdle;
      endcase
    end
  end

  assign tx_o       = ((tx_state_q == TxShift) ? tx_shift_q[0] : 1'b1) | ~rst_ni;
  assign tx_ready_o = ~hold_full_q;
  assign tx_busy_o  = (tx_state_q == TxShift) | hold_full_q;

  serial_peer_rx u_rx (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .tick_i         (tick),
    .rx_i           (rx_i),
    .rx_ack_i       (rx_ack_i),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_frame_err_o (rx_frame_err_o),
    .rx_overrun_o   (rx_overrun_o)
  );

endmodule

// File: tb/tb_serial_peer_uart.sv
// Self-checking bench for serial_peer_uart: directed plan plus randomized rx/tx traffic.
module tb_serial_peer_uart;

  localparam int unsigned Cpb     = 256;
  localparam int unsigned TickDiv = Cpb / 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx, tx;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack, rx_frame_err, rx_overrun;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Receiver reference state
  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;

  int          lat;
  int unsigned t0, ta, ts;

  serial_peer_uart #(.ClksPerBit(Cpb)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rx_i           (rx),
    .tx_o           (tx),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .tx_busy_o      (tx_busy),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ack_i       (rx_ack),
    .rx_frame_err_o (rx_frame_err),
    .rx_overrun_o   (rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack_same);
    if (stop) begin
      m_ovr   = m_valid && !ack_same;
      m_data  = b;
      m_valid = 1'b1;
      m_ferr  = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic rx_expect(input string tag);
    check({tag, "_data"}, rx_data, m_data);
    check({tag, "_valid"}, rx_valid, m_valid);
    check({tag, "_ferr"}, rx_frame_err, m_ferr);
    check({tag, "_ovr"}, rx_overrun, m_ovr);
  endtask

  task automatic align();
    do begin
      @(posedge clk); #1;
    end while (cyc % TickDiv != 0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (Cpb) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  // Send one frame, let it settle, fold it into the model and compare.
  task automatic rx_frame_checked(input logic [7:0] b, input logic stop, input string tag);
    rx_frame(b, stop);
    repeat (128) @(negedge clk);
    model_frame(b, stop, 1'b0);
    rx_expect(tag);
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic pulse_ack(input string tag);
    @(posedge clk); #1 rx_ack = 1'b1;
    @(posedge clk); #1 rx_ack = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0;
    @(negedge clk);
    rx_expect(tag);
  endtask

  task automatic tx_send(input logic [7:0] b, output int unsigned acc);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (tx_ready !== 1'b1 && k < 40 * Cpb) begin
      @(posedge clk); #1;
      k++;
    end
    check("tx_ready_wait", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    acc      = cyc;
    tx_valid = 1'b0;
    check("tx_ready_drop", tx_ready, 1'b0);
  endtask

  // Compare tx every cycle against the ideal 8N1 bit stream of nbytes bytes.
  task automatic tx_stream(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                           input string tag, output int unsigned t_start);
    logic       q[$];
    logic [7:0] b;
    int         errs;
    logic       seen;
    for (int n = 0; n < nbytes; n++) begin
      b = (n == 0) ? b0 : b1;
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(b[i]);
      q.push_back(1'b1);
    end
    seen = 1'b0; errs = 0; t_start = 0;
    for (int k = 0; k < 20 * Cpb && !seen; k++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen    = 1'b1;
        t_start = cyc;
      end
    end
    check({tag, "_start_seen"}, seen, 1'b1);
    if (!seen) return;
    check({tag, "_ready_freed"}, tx_ready, 1'b1);
    for (int i = 0; i < q.size() * Cpb; i++) begin
      if (tx !== q[i / Cpb] || tx_busy !== 1'b1) errs++;
      @(negedge clk);
    end
    check({tag, "_wave_errs"}, errs, 0);
    check({tag, "_idle_tx"}, tx, 1'b1);
    check({tag, "_idle_busy"}, tx_busy, 1'b0);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    int unsigned dummy;

    rst_n = 1'b0; rx = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    rx_expect("rst");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single byte 0xA5 with latency bound
    fork
      tx_send(8'hA5, ta);
      tx_stream(8'hA5, 8'h00, 1, "tx_a5", ts);
    join
    check("tx_latency", (ts > ta) && (ts - ta <= TickDiv), 1'b1);

    // Back-to-back 0x01, 0x80 with no idle gap
    fork
      begin
        tx_send(8'h01, ta);
        tx_send(8'h80, dummy);
      end
      tx_stream(8'h01, 8'h80, 2, "tx_b2b", ts);
    join

    // RX 0x3C, measuring completion latency for the coincident-ack case
    align();
    t0 = cyc;
    lat = -1;
    fork
      rx_frame(8'h3C, 1'b1);
      for (int k = 0; k < 11 * Cpb; k++) begin
        @(negedge clk);
        if (rx_valid === 1'b1 && lat < 0) lat = int'(cyc - t0);
      end
    join
    model_frame(8'h3C, 1'b1, 1'b0);
    rx_expect("rx_3c");
    check("rx_latency_ok", (lat > 0) && (lat <= 2560 + 128), 1'b1);
    if (lat <= 1) lat = 2500;
    pulse_ack("rx_3c_ack");
    repeat (Cpb) @(negedge clk);

    // Overrun, then ack clears it
    rx_frame_checked(8'h11, 1'b1, "ovr_11");
    rx_frame_checked(8'h22, 1'b1, "ovr_22");
    pulse_ack("ovr_ack");

    // Overrun suppressed when ack coincides with completion
    rx_frame_checked(8'h11, 1'b1, "coin_11");
    align();
    t0 = cyc;
    fork
      rx_frame(8'h22, 1'b1);
      begin
        while (cyc != t0 + lat - 1) begin
          @(posedge clk); #1;
        end
        rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
      end
    join
    repeat (128) @(negedge clk);
    model_frame(8'h22, 1'b1, 1'b1);
    rx_expect("coin_22");
    pulse_ack("coin_ack");
    repeat (Cpb) @(negedge clk);

    // Framing error, then recovery on a good frame
    rx_frame_checked(8'h55, 1'b0, "ferr_55");
    repeat (Cpb) @(negedge clk);
    rx_frame_checked(8'h66, 1'b1, "ferr_66");

    // 48-clock glitch and 64-clock false start change nothing
    @(posedge clk); #1 rx = 1'b0;
    repeat (48) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
    rx_expect("glitch48");
    @(posedge clk); #1 rx = 1'b0;
    repeat (64) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
    rx_expect("false_start");
    rx_frame_checked(8'h9D, 1'b1, "after_false");
    pulse_ack("after_false_ack");

    // Randomized receive traffic
    for (int n = 0; n < 5; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 63)) @(posedge clk);
      #1;
      rx_frame_checked(rb, rs, "rx_rand");
      if ($urandom_range(0, 1) == 1) pulse_ack("rx_rand_ack");
    end

    // Randomized transmit traffic
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom);
      repeat ($urandom_range(0, 40)) @(negedge clk);
      fork
        tx_send(rb, ta);
        tx_stream(rb, 8'h00, 1, "tx_rand", ts);
      join
      check("tx_rand_latency", (ts > ta) && (ts - ta <= TickDiv), 1'b1);
    end

    // Reset in the middle of a transmit frame with an unread rx byte
    rx_frame_checked(8'hC3, 1'b1, "pre_reset");
    tx_send(8'h00, ta);
    repeat (1000) @(negedge clk);
    check("pre_reset_tx", tx, 1'b0);
    check("pre_reset_busy", tx_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_reset_tx", tx, 1'b1);
    check("mid_reset_ready", tx_ready, 1'b1);
    check("mid_reset_busy", tx_busy, 1'b0);
    rx_expect("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_tx", tx, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
